hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
Pipeline sequencing controller for the 5-stage RV32IM core; companion to forwarding_unit.
- Resolves the hazards forwarding cannot cover: load-use, multi-cycle MUL/DIV occupancy, data-memory wait, taken-branch squash.
- Drives per-register stall/flush enables for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Outputs are Mealy: decoded from the registered state plus current-cycle inputs.

Parameters:
MDU_MAX_CYCLES, 34, longest permitted MDU busy window before timeout release
CNT_W, 6, width of the MDU wait counter (must hold MDU_MAX_CYCLES)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-low reset
ADDR1  input  5  rs1 of instruction in ID
ADDR2  input  5  rs2 of instruction in ID
USE_RS1  input  1  ID instruction reads rs1
USE_RS2  input  1  ID instruction reads rs2
ID_OPCODE  input  7  opcode in ID (store detection)
EXE_ADDR  input  5  rd of instruction in EX
EXE_MEMREAD  input  1  EX instruction is a load
EXE_MDU_OP  input  1  EX instruction is MUL/DIV/REM
MDU_READY  input  1  MDU result valid this cycle
BRANCH_TAKEN  input  1  EX resolved a taken branch/jump
DMEM_BUSY  input  1  data memory not ready
STALL_PC, STALL_IF_ID, STALL_ID_EX, STALL_EX_MEM, STALL_MEM_WB  output  1 each  hold register
FLUSH_IF_ID, FLUSH_ID_EX, FLUSH_EX_MEM  output  1 each  load bubble (NOP)
MDU_TIMEOUT  output  1  sticky error flag
HCU_STATE  output  2  current state (debug)

Behaviour:
- States: RUN=0, MEM_WAIT=1, MDU_WAIT=2.
- RESET=0 at an edge: state→RUN, counter→0, MDU_TIMEOUT→0.
- While RESET=0, all stall/flush outputs are forced to 0.
- Reset mid-wait aborts the wait, with no flush issued.
- Priority, highest first: DMEM_BUSY > MDU wait > BRANCH_TAKEN > load-use.
- DMEM_BUSY=1 (any state):
  - All five STALL_*=1, no flushes.
  - Next state MEM_WAIT; return to RUN the cycle after DMEM_BUSY=0.
  - An MDU counter in progress is frozen, not cleared.
  - A pending branch stays in EX and is honoured once released.
- MDU wait (EXE_MDU_OP=1, MDU_READY=0, not timed out):
  - STALL_PC/IF_ID/ID_EX=1, FLUSH_EX_MEM=1; MEM/WB keep flowing.
  - State MDU_WAIT; counter increments each cycle.
  - MDU_READY=1 → outputs released that same cycle, counter→0, next RUN.
  - Counter reaching MDU_MAX_CYCLES → MDU_TIMEOUT sets (sticky until reset), stall released, next RUN.
- Branch (RUN, BRANCH_TAKEN=1): FLUSH_IF_ID=1 and FLUSH_ID_EX=1 for exactly that cycle, no stall. This overrides any simultaneous load-use (the ID instruction is squashed).
- Load-use (RUN), when EXE_MEMREAD=1 and EXE_ADDR≠0 and any of:
  - USE_RS1 and ADDR1==EXE_ADDR
  - USE_RS2 and ADDR2==EXE_ADDR, and ID_OPCODE≠STORE_OPCODE (store data is forwarded in MEM)
  Response: STALL_PC=1, STALL_IF_ID=1, FLUSH_ID_EX=1 for one cycle. The bubble clears the condition next cycle, so there is no state change.
- x0 is never a hazard source.
- HCU_STATE reflects the registered state.

Optional Feature:
HCU_PERF_COUNTERS_EN
- Defined: adds 32-bit outputs LOADUSE_STALLS, MDU_STALLS, MEM_STALLS, BRANCH_FLUSHES.
  - Each increments once per cycle its condition drives the outputs.
  - Reset to 0; wrap modulo 2^32.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package/encodings file holds: state encodings (HCU_RUN, HCU_MEM_WAIT, HCU_MDU_WAIT); STORE_OPCODE, R_TYPE_OPCODE etc.; priority constants.
- One sub-module, hcu_loaduse_detect: pure combinational comparator producing LOADUSE_HAZARD.

Test Plan:
- EXE_MEMREAD=1, EXE_ADDR=1, ADDR2=1, USE_RS2=1, ID_OPCODE=R_TYPE → STALL_PC=STALL_IF_ID=FLUSH_ID_EX=1 for 1 cycle, then 0. Same with ID_OPCODE=STORE → all 0.
- EXE_ADDR=0, EXE_MEMREAD=1, ADDR1=0, USE_RS1=1 → no stall.
- EXE_MDU_OP=1, MDU_READY=0 for 10 cycles then 1 → 10 cycles of STALL_PC/IF_ID/ID_EX=1, FLUSH_EX_MEM=1, HCU_STATE=2; released in the ready cycle; MDU_TIMEOUT=0.
- MDU_READY held 0 with MDU_MAX_CYCLES=34 → MDU_TIMEOUT=1 after 34 stall cycles, stall released, flag stays 1 until RESET=0.
- BRANCH_TAKEN=1 concurrent with a load-use match → FLUSH_IF_ID=FLUSH_ID_EX=1, STALL_PC=0.
- DMEM_BUSY=1 for 3 cycles with BRANCH_TAKEN=1 → all STALL_*=1, no flush for 3 cycles; flush pair on 4th cycle.
- RESET=0 during MDU_WAIT → next cycle state RUN, outputs 0, counter 0.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared encodings for the hazard control unit
//   - hcu_state_e : FSM state encodings (debug-visible on HCU_STATE)
//   - hcu_cause_e : hazard causes, encoded so a larger value wins arbitration
//   - opcodes     : RV32 opcodes needed for hazard qualification
//   - hcu_pick_cause : fixed-priority arbiter over the hazard causes
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        HCU_RUN      = 2'd0,
        HCU_MEM_WAIT = 2'd1,
        HCU_MDU_WAIT = 2'd2
    } hcu_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_LOADUSE = 3'd1,
        CAUSE_BRANCH  = 3'd2,
        CAUSE_MDU     = 3'd3,
        CAUSE_MEM     = 3'd4
    } hcu_cause_e;

    localparam logic [6:0] STORE_OPCODE  = 7'b0100011;
    localparam logic [6:0] R_TYPE_OPCODE = 7'b0110011;

    function automatic hcu_cause_e hcu_pick_cause(
        input logic mem,
        input logic mdu,
        input logic br,
        input logic lu
    );
        return mem ? CAUSE_MEM : mdu ? CAUSE_MDU : br ? CAUSE_BRANCH : lu ? CAUSE_LOADUSE : CAUSE_NONE;
    endfunction

endpackage

// File: rtl/hcu_loaduse_detect.sv
// hcu_loaduse_detect: combinational load-use hazard comparator
//   Inputs : ADDR1/ADDR2, USE_RS1/USE_RS2, ID_OPCODE (ID stage),
//            EXE_ADDR, EXE_MEMREAD (EX stage)
//   Output : LOADUSE_HAZARD, high when the ID instruction needs a load
//            result that forwarding cannot deliver in time
module hcu_loaduse_detect
    import hazard_control_unit_pkg::*;
(
    input  logic [4:0] ADDR1,
    input  logic [4:0] ADDR2,
    input  logic       USE_RS1,
    input  logic       USE_RS2,
    input  logic [6:0] ID_OPCODE,
    input  logic [4:0] EXE_ADDR,
    input  logic       EXE_MEMREAD,
    output logic       LOADUSE_HAZARD
);

    // A store's rs2 is only data, forwarded later in MEM, so it never stalls.
    assign LOADUSE_HAZARD = EXE_MEMREAD && (EXE_ADDR != 5'd0) &&
                            ((USE_RS1 && (ADDR1 == EXE_ADDR)) ||
                             (USE_RS2 && (ADDR2 == EXE_ADDR) && (ID_OPCODE != STORE_OPCODE)));

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush sequencer for the 5-stage RV32IM core
//   Inputs : CLK, RESET (sync, active-low), ID operands (ADDR1/2, USE_RS1/2,
//            ID_OPCODE), EX status (EXE_ADDR, EXE_MEMREAD, EXE_MDU_OP,
//            BRANCH_TAKEN), MDU_READY, DMEM_BUSY
//   Outputs: STALL_* (hold register), FLUSH_* (insert bubble), sticky
//            MDU_TIMEOUT, HCU_STATE (registered state, debug)
//   Option : define HCU_PERF_COUNTERS_EN to add 32-bit event counters
//            LOADUSE_STALLS, MDU_STALLS, MEM_STALLS, BRANCH_FLUSHES
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MDU_MAX_CYCLES = 34,
    parameter int CNT_W          = 6
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ADDR1,
    input  logic [4:0]  ADDR2,
    input  logic        USE_RS1,
    input  logic        USE_RS2,
    input  logic [6:0]  ID_OPCODE,
    input  logic [4:0]  EXE_ADDR,
    input  logic        EXE_MEMREAD,
    input  logic        EXE_MDU_OP,
    input  logic        MDU_READY,
    input  logic        BRANCH_TAKEN,
    input  logic        DMEM_BUSY,
    output logic        STALL_PC,
    output logic        STALL_IF_ID,
    output logic        STALL_ID_EX,
    output logic        STALL_EX_MEM,
    output logic        STALL_MEM_WB,
    output logic        FLUSH_IF_ID,
    output logic        FLUSH_ID_EX,
    output logic        FLUSH_EX_MEM,
    output logic        MDU_TIMEOUT,
    output logic [1:0]  HCU_STATE
`ifdef HCU_PERF_COUNTERS_EN
    ,
    output logic [31:0] LOADUSE_STALLS,
    output logic [31:0] MDU_STALLS,
    output logic [31:0] MEM_STALLS,
    output logic [31:0] BRANCH_FLUSHES
`endif
);

    hcu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             timeout_d;
    logic             loaduse;
    logic             mdu_wait;
    hcu_cause_e       cause;

    hcu_loaduse_detect u_loaduse_detect (
        .ADDR1          (ADDR1),
        .ADDR2          (ADDR2),
        .USE_RS1        (USE_RS1),
        .USE_RS2        (USE_RS2),
        .ID_OPCODE      (ID_OPCODE),
        .EXE_ADDR       (EXE_ADDR),
        .EXE_MEMREAD    (EXE_MEMREAD),
        .LOADUSE_HAZARD (loaduse)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= HCU_RUN;
            cnt_q       <= '0;
            MDU_TIMEOUT <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            MDU_TIMEOUT <= timeout_d;
        end
    end

    // Outputs depend only on current inputs and the wait counter, so a branch
    // held in EX during a memory wait is honoured in the first released cycle.
    always_comb begin
        cnt_inc      = cnt_q + CNT_W'(1);
        // Once the counter has reached the limit the wait is abandoned.
        mdu_wait     = EXE_MDU_OP && !MDU_READY && (cnt_q != CNT_W'(MDU_MAX_CYCLES));
        cause        = RESET ? hcu_pick_cause(DMEM_BUSY, mdu_wait, BRANCH_TAKEN, loaduse) : CAUSE_NONE;
        STALL_PC     = (cause == CAUSE_MEM) || (cause == CAUSE_MDU) || (cause == CAUSE_LOADUSE);
        STALL_IF_ID  = STALL_PC;
        STALL_ID_EX  = (cause == CAUSE_MEM) || (cause == CAUSE_MDU);
        STALL_EX_MEM = (cause == CAUSE_MEM);
        STALL_MEM_WB = (cause == CAUSE_MEM);
        FLUSH_IF_ID  = (cause == CAUSE_BRANCH);
        FLUSH_ID_EX  = (cause == CAUSE_BRANCH) || (cause == CAUSE_LOADUSE);
        FLUSH_EX_MEM = (cause == CAUSE_MDU);
        state_d      = (cause == CAUSE_MEM) ? HCU_MEM_WAIT :
                       (cause == CAUSE_MDU) ? HCU_MDU_WAIT : HCU_RUN;
        // A memory wait freezes an MDU count in progress rather than clearing it.
        cnt_d        = (cause == CAUSE_MEM) ? cnt_q :
                       (cause == CAUSE_MDU) ? cnt_inc : '0;
        timeout_d    = MDU_TIMEOUT || ((cause == CAUSE_MDU) && (cnt_inc == CNT_W'(MDU_MAX_CYCLES)));
    end

    assign HCU_STATE = state_q;

`ifdef HCU_PERF_COUNTERS_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            LOADUSE_STALLS <= '0;
            MDU_STALLS     <= '0;
            MEM_STALLS     <= '0;
            BRANCH_FLUSHES <= '0;
        end else begin
            LOADUSE_STALLS <= LOADUSE_STALLS + 32'((cause == CAUSE_LOADUSE));
            MDU_STALLS     <= MDU_STALLS + 32'((cause == CAUSE_MDU));
            MEM_STALLS     <= MEM_STALLS + 32'((cause == CAUSE_MEM));
            BRANCH_FLUSHES <= BRANCH_FLUSHES + 32'((cause == CAUSE_BRANCH));
        end
    end
`endif

endmodule
